// File: rtl/lcd_frame_ctrl_if.sv
// Character-write bus for lcd_frame_ctrl: one (row, col, char) write per cycle
// while wr_en is high; there is no backpressure.
interface lcd_frame_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [5:0] wr_col;
    logic [7:0] wr_char;

    modport master (output wr_en, wr_row, wr_col, wr_char);
    modport slave  (input  wr_en, wr_row, wr_col, wr_char);
endinterface

// File: rtl/lcd_frame_ctrl.sv
// HD44780-style 8-bit character LCD controller with a ROWS x COLS frame buffer.
// Runs the power-up init sequence once, then refreshes the panel from the
// buffer in a loop: ROW_ADDR + COLS chars per row, followed by an idle gap.
// Optional feature macro: LCD_DIRTY_SKIP_EN -- when defined, the controller
// holds in the gap after a frame until the buffer has been written again.
module lcd_frame_ctrl #(
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned PWRUP_CYC   = 70,
    parameter int unsigned CMD_CYC     = 32,
    parameter int unsigned E_HIGH      = 4,
    parameter int unsigned CLR_CYC     = 200,
    parameter int unsigned REFRESH_CYC = 400
) (
    input  logic                clk,
    input  logic                rst,
    lcd_frame_ctrl_if.slave     wr,
    output logic                init_done,
    output logic                frame_done,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [7:0]          lcd_data
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [15:0]   PWRUP_LAST = 16'(PWRUP_CYC - 1);
    localparam logic [15:0]   CMD_LAST   = 16'(CMD_CYC - 1);
    localparam logic [15:0]   CLR_LAST   = 16'(CLR_CYC - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(REFRESH_CYC - 1);
    localparam logic [15:0]   E_LAST     = 16'(E_HIGH);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, FSET, DISP_ON, ENTRY, CLEAR, ROW_ADDR, CHAR, GAP
    } state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;
    logic [15:0]   tx_last;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;
    logic          init_done_q;
    logic          frame_done_q;
    logic          wr_ok;
    logic [7:0]    buf_q [ROWS][COLS];
`ifdef LCD_DIRTY_SKIP_EN
    logic          dirty_q;
`endif

    // Set DDRAM address command for the start of row r.
    function automatic logic [7:0] row_cmd(input logic [RW-1:0] r);
        logic [1:0] r2;
        r2 = 2'(r);
        case (r2)
            2'd0:    row_cmd = 8'h80;
            2'd1:    row_cmd = 8'h80 | 8'h40;
            2'd2:    row_cmd = 8'h80 | 8'(COLS);
            default: row_cmd = 8'h80 | (8'h40 + 8'(COLS));
        endcase
    endfunction

    // Write qualification, cycle counter increment and current transaction length.
    always_comb begin
        wr_ok   = wr.wr_en && ({1'b0, wr.wr_row} < 3'(ROWS)) && ({1'b0, wr.wr_col} < 7'(COLS));
        cnt_d   = cnt_q + 16'd1;
        tx_last = (state_q == CLEAR) ? CLR_LAST : CMD_LAST;
    end

    // Frame buffer: spaces after reset, one character per accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '{default: 8'h20};
        end else if (wr_ok) begin
            buf_q[wr.wr_row[RW-1:0]][wr.wr_col[CW-1:0]] <= wr.wr_char;
        end
    end

    // Sequencer: power-up wait, init commands, then row/char refresh with gaps.
    // Bus outputs are loaded on the edge that starts a transaction, so a
    // character byte is sampled from the buffer before a same-cycle write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
            dirty_q      <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
`ifdef LCD_DIRTY_SKIP_EN
            if (wr_ok) begin
                dirty_q <= 1'b1;
            end
`endif
            unique case (state_q)
                PWR_WAIT: begin
                    if (cnt_q == PWRUP_LAST) begin
                        state_q    <= FSET;
                        cnt_q      <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= 8'h38;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
`ifdef LCD_DIRTY_SKIP_EN
                        if (dirty_q || wr_ok) begin
                            state_q    <= ROW_ADDR;
                            cnt_q      <= '0;
                            row_q      <= '0;
                            lcd_rs_q   <= 1'b0;
                            lcd_data_q <= row_cmd(RW'(0));
                            dirty_q    <= 1'b0;
                        end
`else
                        state_q    <= ROW_ADDR;
                        cnt_q      <= '0;
                        row_q      <= '0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= row_cmd(RW'(0));
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    if (cnt_q != tx_last) begin
                        cnt_q   <= cnt_d;
                        lcd_e_q <= (cnt_d <= E_LAST);
                        if (state_q == CHAR && row_q == ROW_LAST && col_q == COL_LAST &&
                            cnt_d == tx_last) begin
                            frame_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= '0;
                        lcd_e_q <= 1'b0;
                        case (state_q)
                            FSET: begin
                                state_q    <= DISP_ON;
                                lcd_data_q <= 8'h0C;
                            end
                            DISP_ON: begin
                                state_q    <= ENTRY;
                                lcd_data_q <= 8'h06;
                            end
                            ENTRY: begin
                                state_q    <= CLEAR;
                                lcd_data_q <= 8'h01;
                            end
                            CLEAR: begin
                                state_q     <= ROW_ADDR;
                                init_done_q <= 1'b1;
                                row_q       <= '0;
                                lcd_data_q  <= row_cmd(RW'(0));
`ifdef LCD_DIRTY_SKIP_EN
                                dirty_q     <= 1'b0;
`endif
                            end
                            ROW_ADDR: begin
                                state_q    <= CHAR;
                                col_q      <= '0;
                                lcd_rs_q   <= 1'b1;
                                lcd_data_q <= buf_q[row_q][CW'(0)];
                            end
                            CHAR: begin
                                if (col_q == COL_LAST) begin
                                    col_q <= '0;
                                    if (row_q == ROW_LAST) begin
                                        state_q <= GAP;
                                        row_q   <= '0;
                                    end else begin
                                        state_q    <= ROW_ADDR;
                                        row_q      <= row_q + RW'(1);
                                        lcd_rs_q   <= 1'b0;
                                        lcd_data_q <= row_cmd(row_q + RW'(1));
                                    end
                                end else begin
                                    col_q      <= col_q + CW'(1);
                                    lcd_data_q <= buf_q[row_q][col_q + CW'(1)];
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_ctrl.sv
// Self-checking bench for lcd_frame_ctrl (COLS=16 ROWS=2 PWRUP=100 CMD=8
// E_HIGH=3 CLR=40 REFRESH=50). Expected bus transactions are pushed to a
// scoreboard from a local frame-buffer model; a monitor captures each strobe.
`timescale 1ns/1ps
module tb_lcd_frame_ctrl;

    localparam int unsigned COLS  = 16;
    localparam int unsigned ROWS  = 2;
    localparam int unsigned PWRUP = 100;
    localparam int unsigned CMD   = 8;
    localparam int unsigned EH    = 3;
    localparam int unsigned CLR   = 40;
    localparam int unsigned REF   = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done, frame_done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_frame_ctrl_if wr();

    lcd_frame_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .PWRUP_CYC(PWRUP), .CMD_CYC(CMD),
        .E_HIGH(EH), .CLR_CYC(CLR), .REFRESH_CYC(REF)
    ) dut (
        .clk(clk), .rst(rst), .wr(wr),
        .init_done(init_done), .frame_done(frame_done),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic rs; logic [7:0] data; int unsigned start; } exp_t;
    typedef struct { logic rs; logic [7:0] data; int unsigned hi; int unsigned start; } obs_t;

    exp_t        exp_q[$];
    obs_t        mon_q[$];
    int unsigned fd_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc;
    int unsigned last_start;
    logic [7:0]  model [ROWS][COLS];

    // Cycle index since reset release: cycle k follows the k-th rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: one record per strobe (bus value, high width, transaction start).
    initial begin : monitor
        obs_t cur;
        logic e_prev;
        e_prev = 1'b0;
        cur = '{rs: 1'b0, data: 8'h00, hi: 0, start: 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                e_prev = 1'b0;
            end else begin
                if (lcd_e && !e_prev) begin
                    cur.rs = lcd_rs; cur.data = lcd_data; cur.hi = 1; cur.start = cyc - 1;
                end else if (lcd_e) begin
                    cur.hi++;
                end else if (e_prev) begin
                    mon_q.push_back(cur);
                end
                if (frame_done) fd_q.push_back(cyc);
                e_prev = lcd_e;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r][c] = 8'h20;
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] data, input int unsigned start);
        exp_t e;
        e.rs = rs; e.data = data; e.start = start;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int unsigned start);
        int unsigned k = 0;
        for (int r = 0; r < ROWS; r++) begin
            push_exp(1'b0, (r == 0) ? 8'h80 : 8'hC0, start + CMD * k); k++;
            for (int c = 0; c < COLS; c++) begin
                push_exp(1'b1, model[r][c], start + CMD * k); k++;
            end
        end
    endtask

    // Called at a negedge; holds the write for exactly one rising edge.
    task automatic do_write(input int unsigned r, input int unsigned c, input logic [7:0] ch);
        wr.wr_en = 1'b1; wr.wr_row = 2'(r); wr.wr_col = 6'(c); wr.wr_char = ch;
        if (r < ROWS && c < COLS) model[r][c] = ch;
        @(negedge clk);
        wr.wr_en = 1'b0;
    endtask

    task automatic get_obs(output obs_t o, output bit ok);
        int unsigned n = 0;
        while (mon_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        ok = (mon_q.size() != 0);
        if (ok) o = mon_q.pop_front();
        else    o = '{rs: 1'b0, data: 8'h00, hi: 0, start: 0};
    endtask

    task automatic wait_cycle(input int unsigned target, input string name);
        int unsigned n = 0;
        while (cyc != target && n < 3000) begin @(negedge clk); n++; end
        n_cmp++;
        if (cyc !== target) begin
            $display("FAIL %s: cycle %0d never reached (now %0d)", name, target, cyc);
            n_err++;
        end
    endtask

    // Scoreboard drain: pop n expectations and compare with captured strobes.
    task automatic drain(input int unsigned n, input string name);
        exp_t ex; obs_t ob; bit ok;
        for (int unsigned i = 0; i < n; i++) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s[%0d]: scoreboard empty, got nothing to compare, want an entry", name, i);
                n_err++; return;
            end
            ex = exp_q.pop_front();
            get_obs(ob, ok);
            if (!ok) begin
                $display("FAIL %s[%0d] timeout: no strobe, want rs=%0d data=0x%02h", name, i, ex.rs, ex.data);
                n_err++; return;
            end
            if ({ob.rs, ob.data} !== {ex.rs, ex.data}) begin
                $display("FAIL %s[%0d] bus: got rs=%0d data=0x%02h, want rs=%0d data=0x%02h",
                         name, i, ob.rs, ob.data, ex.rs, ex.data);
                n_err++;
            end
            n_cmp++;
            if (ob.start !== ex.start) begin
                $display("FAIL %s[%0d] start: got cycle %0d, want %0d", name, i, ob.start, ex.start);
                n_err++;
            end
            n_cmp++;
            if (ob.hi !== EH) begin
                $display("FAIL %s[%0d] e_width: got %0d, want %0d", name, i, ob.hi, EH);
                n_err++;
            end
            last_start = ob.start;
        end
    endtask

    task automatic check_fd(input string name);
        int unsigned n = 0;
        int unsigned f;
        while (fd_q.size() == 0 && n < 20) begin @(negedge clk); n++; end
        n_cmp++;
        if (fd_q.size() == 0) begin
            $display("FAIL %s frame_done: got no pulse, want one at cycle %0d", name, last_start + CMD - 1);
            n_err++; return;
        end
        f = fd_q.pop_front();
        if (f !== last_start + CMD - 1) begin
            $display("FAIL %s frame_done: got cycle %0d, want %0d", name, f, last_start + CMD - 1);
            n_err++;
        end
        @(negedge clk);
        n_cmp++;
        if (fd_q.size() !== 0) begin
            $display("FAIL %s frame_done_width: got %0d extra samples, want 0", name, fd_q.size());
            n_err++;
            fd_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (lcd_e !== 1'b0)      begin $display("FAIL reset lcd_e: got %b want 0", lcd_e); n_err++; end
        n_cmp++; if (lcd_rs !== 1'b0)     begin $display("FAIL reset lcd_rs: got %b want 0", lcd_rs); n_err++; end
        n_cmp++; if (lcd_rw !== 1'b0)     begin $display("FAIL reset lcd_rw: got %b want 0", lcd_rw); n_err++; end
        n_cmp++; if (lcd_data !== 8'h00)  begin $display("FAIL reset lcd_data: got 0x%02h want 0x00", lcd_data); n_err++; end
        n_cmp++; if (init_done !== 1'b0)  begin $display("FAIL reset init_done: got %b want 0", init_done); n_err++; end
        n_cmp++; if (frame_done !== 1'b0) begin $display("FAIL reset frame_done: got %b want 0", frame_done); n_err++; end
        rst = 1'b0;
    endtask

    task automatic test_init(input string name);
        push_exp(1'b0, 8'h38, PWRUP);
        push_exp(1'b0, 8'h0C, PWRUP + CMD);
        push_exp(1'b0, 8'h06, PWRUP + 2 * CMD);
        push_exp(1'b0, 8'h01, PWRUP + 3 * CMD);
        drain(4, name);
        wait_cycle(PWRUP + 3 * CMD + CLR - 1, name);
        n_cmp++;
        if (init_done !== 1'b0) begin $display("FAIL %s init_done_early: got %b want 0", name, init_done); n_err++; end
        @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b1) begin $display("FAIL %s init_done: got %b want 1", name, init_done); n_err++; end
    endtask

    task automatic test_idle_frame();
        push_frame(PWRUP + 3 * CMD + CLR);
        drain(ROWS * (COLS + 1), "idle_frame");
        check_fd("idle_frame");
    endtask

    task automatic test_ignored_writes();
        int unsigned nxt = last_start + CMD + REF;
        do_write(2, 0, 8'h58);
        do_write(0, 16, 8'h58);
        do_write(3, 5, 8'h58);
        do_write(0, 15, 8'h20);
        push_frame(nxt);
        drain(ROWS * (COLS + 1), "ignored_writes");
        check_fd("ignored_writes");
    endtask

    task automatic test_write_chars();
        int unsigned nxt = last_start + CMD + REF;
        do_write(1, 5, 8'h50);
        do_write(0, 0, 8'h41);
        push_frame(nxt);
        drain(ROWS * (COLS + 1), "write_chars");
        check_fd("write_chars");
    endtask

    task automatic test_collision();
        int unsigned f4 = last_start + CMD + REF;
        do_write(0, 15, 8'h20);
        push_frame(f4);
        wait_cycle(f4 + 4 * CMD, "collision_sync");
        do_write(0, 3, 8'h5A);
        push_frame(f4 + (ROWS * (COLS + 1) - 1) * CMD + CMD + REF);
        drain(ROWS * (COLS + 1), "collision_old");
        check_fd("collision_old");
        drain(ROWS * (COLS + 1), "collision_new");
        check_fd("collision_new");
    endtask

    task automatic test_reset_mid_tx();
        int unsigned n = 0;
        do_write(0, 15, 8'h20);
        while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 3000) begin @(negedge clk); n++; end
        n_cmp++;
        if (!(lcd_e === 1'b1 && lcd_rs === 1'b1)) begin
            $display("FAIL reset_mid_tx sync: got no char strobe, want lcd_e=1 rs=1");
            n_err++;
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (lcd_e !== 1'b0)     begin $display("FAIL reset_mid_tx lcd_e: got %b want 0", lcd_e); n_err++; end
        n_cmp++; if (lcd_data !== 8'h00) begin $display("FAIL reset_mid_tx lcd_data: got 0x%02h want 0x00", lcd_data); n_err++; end
        n_cmp++; if (init_done !== 1'b0) begin $display("FAIL reset_mid_tx init_done: got %b want 0", init_done); n_err++; end
        repeat (3) @(negedge clk);
        mon_q.delete(); exp_q.delete(); fd_q.delete();
        model_clear();
        rst = 1'b0;
        test_init("reinit");
        push_frame(PWRUP + 3 * CMD + CLR);
        drain(ROWS * (COLS + 1), "frame_after_reset");
        check_fd("frame_after_reset");
    endtask

`ifdef LCD_DIRTY_SKIP_EN
    task automatic test_dirty_skip();
        int unsigned w;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (mon_q.size() !== 0) begin $display("FAIL dirty_idle strobes: got %0d, want 0", mon_q.size()); n_err++; end
        n_cmp++;
        if (lcd_e !== 1'b0) begin $display("FAIL dirty_idle lcd_e: got %b want 0", lcd_e); n_err++; end
        w = cyc;
        do_write(1, 2, 8'h51);
        push_frame(w + 1);
        drain(ROWS * (COLS + 1), "dirty_wake");
        check_fd("dirty_wake");
    endtask
`else
    task automatic test_repeat();
        push_frame(last_start + CMD + REF);
        drain(ROWS * (COLS + 1), "repeat_frame");
        check_fd("repeat_frame");
    endtask
`endif

    initial begin
        wr.wr_en = 1'b0; wr.wr_row = '0; wr.wr_col = '0; wr.wr_char = '0;
        model_clear();
        test_reset();
        test_init("init");
        test_idle_frame();
        test_ignored_writes();
        test_write_chars();
        test_collision();
        test_reset_mid_tx();
`ifdef LCD_DIRTY_SKIP_EN
        test_dirty_skip();
`else
        test_repeat();
`endif
        n_cmp++;
        if (lcd_rw !== 1'b0) begin $display("FAIL final lcd_rw: got %b want 0", lcd_rw); n_err++; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
